// File: rtl/addsub_bist_pkg.sv
// Shared types, constants and golden arithmetic for the adder/subtractor BIST checker.
package addsub_bist_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_CHECK,
      S_DONE
   } bist_state_t;

   localparam logic [7:0]  ERR_MAX   = 8'd255;
   localparam int unsigned MAX_WIDTH = 16;
   localparam int unsigned DEF_WIDTH = 4;

   // Golden {carry,sum}: a + (b ^ {width{sel}}) + sel; bits above width are always zero.
   function automatic logic [MAX_WIDTH:0] addsub_expected(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input logic                 sel,
      input int unsigned          width = DEF_WIDTH
   );
      logic [MAX_WIDTH-1:0] keep;
      keep = MAX_WIDTH'((64'd1 << width) - 64'd1);
      return {1'b0, a & keep}
           + {1'b0, (b ^ {MAX_WIDTH{sel}}) & keep}
           + (MAX_WIDTH+1)'(sel);
   endfunction

endpackage

// File: rtl/addsub_ref_model.sv
// Combinational golden model of the WIDTH-bit adder/subtractor.
module addsub_ref_model
   import addsub_bist_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH:0]   expected
);

   assign expected = (WIDTH+1)'(addsub_expected(MAX_WIDTH'(a), MAX_WIDTH'(b), sel, WIDTH));

endmodule

// File: rtl/addsub_bist_checker.sv
// Exhaustive self-test sweep of a combinational adder/subtractor.
// Optional checker self-test: define ADDSUB_BIST_FAULT_INJECT_EN to add the fault_inj input.
module addsub_bist_checker
   import addsub_bist_pkg::*;
#(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef ADDSUB_BIST_FAULT_INJECT_EN
   input  logic                 fault_inj,
`endif
   input  logic                 start,
   output logic [WIDTH-1:0]     A,
   output logic [WIDTH-1:0]     B,
   output logic                 select,
   input  logic [WIDTH-1:0]     sum,
   input  logic                 carry_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [7:0]           err_count,
   output logic [2*WIDTH:0]     first_fail
);

   localparam int unsigned IDX_W = 2*WIDTH + 1;
   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   bist_state_t      state, state_next;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] settle_cnt;
   logic [WIDTH:0]   expected;
   logic [WIDTH:0]   exp_chk;
   logic             mismatch;
   logic             last_vec;
   logic [7:0]       err_inc;

   // Vector index doubles as the registered operand drive.
   assign select = idx[2*WIDTH];
   assign A      = idx[2*WIDTH-1:WIDTH];
   assign B      = idx[WIDTH-1:0];

   addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a        (A),
      .b        (B),
      .sel      (select),
      .expected (expected)
   );

`ifdef ADDSUB_BIST_FAULT_INJECT_EN
   logic fi_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fi_q <= 1'b0;
      else if ((state == S_IDLE || state == S_DONE) && start)
         fi_q <= fault_inj;
   end

   assign exp_chk = expected ^ {{WIDTH{1'b0}}, fi_q && (idx == '0)};
`else
   assign exp_chk = expected;
`endif

   assign mismatch = ({carry_out, sum} != exp_chk);
   assign last_vec = (idx == '1);
   assign err_inc  = (err_count == ERR_MAX) ? ERR_MAX : err_count + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_next = S_DRIVE;
         S_DRIVE:        if (settle_cnt == CNT_LAST) state_next = S_CHECK;
         S_CHECK:        state_next = last_vec ? S_DONE : S_DRIVE;
         default:        state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         first_fail <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  idx        <= '0;
                  settle_cnt <= '0;
                  err_count  <= '0;
                  first_fail <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
               end
            end
            S_DRIVE: begin
               settle_cnt <= settle_cnt + 1'b1;
            end
            S_CHECK: begin
               settle_cnt <= '0;
               if (mismatch) begin
                  err_count <= err_inc;
                  if (err_count == '0)
                     first_fail <= idx;
               end
               if (last_vec) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= !mismatch && (err_count == '0);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_bist_checker.sv
// Directed and randomized checks of the BIST sweep against behavioural adder fault models.
module tb_addsub_bist_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       fault_inj = 1'b0;
   logic [3:0] A, B, sum;
   logic       select, carry_out;
   logic       busy, done, pass;
   logic [7:0] err_count;
   logic [8:0] first_fail;

   int         mode = 0;
   int         fault_idx = 0;
   int         fbit = 0;
   int         n_cmp = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   addsub_bist_checker #(.WIDTH(4), .SETTLE_CYCLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef ADDSUB_BIST_FAULT_INJECT_EN
      .fault_inj  (fault_inj),
`endif
      .start      (start),
      .A          (A),
      .B          (B),
      .select     (select),
      .sum        (sum),
      .carry_out  (carry_out),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail)
   );

   // Correct adder/subtractor by plain integer arithmetic.
   function automatic logic [4:0] golden(input logic [3:0] a, input logic [3:0] b, input logic sel);
      int r;
      logic [4:0] res;
      if (!sel) begin
         r = int'(a) + int'(b);
         res = {r > 15, 4'(r)};
      end else begin
         r = int'(a) - int'(b);
         res = {r >= 0, 4'(r)};
      end
      return res;
   endfunction

   // Adder under test: 0 correct, 1 carry stuck at 0, 2 sum[3] flipped on subtract, 3 one bad vector.
   function automatic logic [4:0] adder_out(input int md, input logic [3:0] a, input logic [3:0] b,
                                            input logic sel, input int fidx, input int fb);
      logic [4:0] g;
      g = golden(a, b, sel);
      case (md)
         1: g[4] = 1'b0;
         2: if (sel) g[3] = ~g[3];
         3: if (int'({sel, a, b}) == fidx) g[fb] = ~g[fb];
         default: ;
      endcase
      return g;
   endfunction

   always_comb {carry_out, sum} = adder_out(mode, A, B, select, fault_idx, fbit);

   // Whole-sweep reference: mismatch count (saturating) and first failing vector.
   task automatic model(input int md, input bit fi, output int ec, output int ff);
      logic [8:0] v;
      logic [4:0] e;
      ec = 0;
      ff = 0;
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         e = golden(v[7:4], v[3:0], v[8]);
         if (fi && i == 0) e[0] = ~e[0];
         if (adder_out(md, v[7:4], v[3:0], v[8], fault_idx, fbit) != e) begin
            if (ec == 0) ff = i;
            if (ec < 255) ec++;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_vec"},   32'({select, A, B}), 32'd0);
      check({tag, "_busy"},  32'(busy),           32'd0);
      check({tag, "_done"},  32'(done),           32'd0);
      check({tag, "_pass"},  32'(pass),           32'd0);
      check({tag, "_err"},   32'(err_count),      32'd0);
      check({tag, "_first"}, 32'(first_fail),     32'd0);
   endtask

   // One sweep from a start pulse; optional start poke at edge 10 or reset at edge rst_at.
   task automatic run_sweep(input string tag, input int md, input bit fi, input bit poke, input int rst_at);
      int n;
      int ec, ff;
      mode = md;
      fault_inj = fi;
      model(md, fi, ec, ff);
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
      n = 0;
      while (n < 2000) begin
         @(posedge clk) #1;
         n++;
         start = (poke && n == 9);
         if (n == 1) begin
            check({tag, "_busy_e1"}, 32'(busy),           32'd1);
            check({tag, "_done_e1"}, 32'(done),           32'd0);
            check({tag, "_vec_e1"},  32'({select, A, B}), 32'd0);
         end
         if (rst_at != 0 && n == rst_at) begin
            #2 rst = 1'b1;
            #1 check_reset_values({tag, "_async_rst"});
            @(negedge clk) rst = 1'b0;
            return;
         end
         if (done) break;
      end
      check({tag, "_done_edge"}, 32'(n),              32'd1536);
      check({tag, "_busy_end"},  32'(busy),           32'd0);
      check({tag, "_err"},       32'(err_count),      32'(ec));
      check({tag, "_first"},     32'(first_fail),     32'(ff));
      check({tag, "_pass"},      32'(pass),           32'(ec == 0));
      check({tag, "_vec_hold"},  32'({select, A, B}), 32'h1FF);
   endtask

   initial begin
      #1 check_reset_values("reset");
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("idle");

      run_sweep("clean", 0, 1'b0, 1'b0, 0);
      run_sweep("carry_stuck0", 1, 1'b0, 1'b0, 0);
      check("carry_stuck0_first_lit", 32'(first_fail), 32'h01F);
      run_sweep("sum3_sub", 2, 1'b0, 1'b0, 0);
      check("sum3_sub_first_lit", 32'(first_fail), 32'h100);

      run_sweep("abort", 0, 1'b0, 1'b0, 700);
      run_sweep("after_abort", 0, 1'b0, 1'b0, 0);
      run_sweep("busy_poke", 0, 1'b0, 1'b1, 0);
      run_sweep("restart_done", 0, 1'b0, 1'b0, 0);

      for (int r = 0; r < 3; r++) begin
         fault_idx = int'($urandom_range(0, 511));
         fbit      = int'($urandom_range(0, 4));
         run_sweep($sformatf("rand%0d", r), 3, 1'b0, 1'b0, 0);
      end

`ifdef ADDSUB_BIST_FAULT_INJECT_EN
      run_sweep("fault_inj", 0, 1'b1, 1'b0, 0);
      run_sweep("fault_inj_off", 0, 1'b0, 1'b0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
